ram_burst_reader: RTL and testbench

Streams a contiguous burst of words out of a `simple_ram` read port as a valid/ready stream. The RAM read is registered, so `q` arrives one cycle after `rdaddress`. The block tracks reads in flight against a 2-entry output buffer, which sustains one word per cycle and honours downstream backpressure without losing data. It sits between a RAM-backed buffer (frame, table or sample store) and any stream consumer.

---
 rtl/ram_burst_reader_pkg.sv | 16 +
 rtl/ram_burst_fifo2.sv | 67 ++++++
 rtl/simple_ram.sv | 26 ++
 rtl/ram_burst_reader.sv | 146 ++++++++++++++
 tb/tb_ram_burst_reader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared constants for the RAM burst reader: FSM encodings and output buffer sizing.
package ram_burst_reader_pkg;

  // FSM state encoding
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_RUN  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DONE = STATE_W'(2);

  // Output buffer depth and the widths derived from it
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  // Occupancy + in-flight needs one more bit than the buffer count
  localparam int unsigned OCC_W      = FIFO_CNT_W + 1;

endpackage

// File: rtl/ram_burst_fifo2.sv
// Two-entry shift FIFO; slot0 is always the head, so the head is a plain register.
module ram_burst_fifo2
  import ram_burst_reader_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [width-1:0]      din,
  input  logic                  pop,
  output logic [width-1:0]      head,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [width-1:0]      slot0_q;
  logic [width-1:0]      slot1_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  full_c;
  logic                  push_c;
  logic                  pop_c;

  // Qualify requests so a misuse can never corrupt the pointers
  assign full_c = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_c  = pop && (count_q != '0);
  assign push_c = push && (!full_c || pop_c);

  // Storage and occupancy; a simultaneous push/pop keeps the count and order
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (count_q == '0) begin
            slot0_q <= din;
          end else begin
            slot1_q <= din;
          end
          count_q <= count_q + FIFO_CNT_W'(1);
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - FIFO_CNT_W'(1);
        end
        2'b11: begin
          if (count_q == FIFO_CNT_W'(1)) begin
            slot0_q <= din;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head  = slot0_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/simple_ram.sv
// Dual-port RAM with a registered read: q follows rdaddress by one clock.
module simple_ram #(
  parameter int unsigned width   = 8,
  parameter int unsigned widthad = 4
) (
  input  logic               clk,
  input  logic [width-1:0]   data,
  input  logic [widthad-1:0] wraddress,
  input  logic               wren,
  input  logic [widthad-1:0] rdaddress,
  output logic [width-1:0]   q
);

  localparam int unsigned DEPTH = 1 << widthad;

  logic [width-1:0] mem [DEPTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[wraddress] <= data;
    end
    q <= mem[rdaddress];
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a contiguous RAM burst out as valid/ready, using credits against a 2-entry buffer.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned widthad = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [widthad-1:0] base_addr,
  input  logic [widthad:0]   length,
  output logic               busy,
  output logic               done,
  output logic [widthad-1:0] rdaddress,
  input  logic [width-1:0]   q,
  output logic [width-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int unsigned CNT_W = widthad + 1;

  logic [STATE_W-1:0]    state_q;
  logic [STATE_W-1:0]    state_d;
  logic [widthad-1:0]    addr_q;
  logic [CNT_W-1:0]      issue_left_q;
  logic [CNT_W-1:0]      accept_left_q;
  logic                  inflight_q;
  logic                  busy_q;
  logic                  done_q;

  logic [width-1:0]      fifo_head;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  logic                  load_c;
  logic                  pop_c;
  logic                  issue_c;
  logic [OCC_W-1:0]      occ_c;

  // A burst is latched only from IDLE, so start is ignored while busy
  assign load_c = (state_q == S_IDLE) && start;

  // Handshake on the buffer head
  assign pop_c = !fifo_empty && out_ready;

  // Words the buffer must still hold after this cycle: stored + returning - leaving
  assign occ_c = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop_c);

  // Issue only when a slot is guaranteed for the word when it returns
  assign issue_c = (state_q == S_RUN) && (issue_left_q != '0)
                   && (occ_c < OCC_W'(FIFO_DEPTH));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((issue_left_q == '0) && (accept_left_q == CNT_W'(1)) && pop_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Address and word counters; the address stops on the final word so rdaddress holds it
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
    end else if (load_c) begin
      if (length != '0) begin
        addr_q <= base_addr;
      end
      issue_left_q  <= length;
      accept_left_q <= length;
    end else begin
      if (issue_c) begin
        issue_left_q <= issue_left_q - CNT_W'(1);
        if (issue_left_q != CNT_W'(1)) begin
          addr_q <= addr_q + widthad'(1);
        end
      end
      if (pop_c && (accept_left_q != '0)) begin
        accept_left_q <= accept_left_q - CNT_W'(1);
      end
    end
  end

  // In-flight flag marks the cycle in which q carries an issued word
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue_c;
    end
  end

  ram_burst_fifo2 #(
    .width (width)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (q),
    .pop   (pop_c),
    .head  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdaddress = addr_q;
  assign out_data  = fifo_head;
  assign out_valid = !fifo_empty;
  assign out_last  = !fifo_empty && (accept_left_q == CNT_W'(1));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader driving a simple_ram model.
module tb_ram_burst_reader;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdaddress;
  logic [W-1:0]  q;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [W-1:0]  wdata;
  logic [AW-1:0] wraddress;
  logic          wren;

  int unsigned   checks;
  int unsigned   failures;
  int unsigned   hs_cnt;
  bit            rdy_mode;
  logic [W-1:0]  model [N];
  logic [W-1:0]  exp_q [$];

  ram_burst_reader #(.width(W), .widthad(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rdaddress (rdaddress),
    .q         (q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  simple_ram #(.width(W), .widthad(AW)) u_ram (
    .clk       (clk),
    .data      (wdata),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: always 1, or random 50% under backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability and buffer occupancy
  initial begin
    bit           hold_v;
    logic [W-1:0] hold_d;
    logic         hold_l;
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        check_eq("occupancy", 32'(dut.fifo_count <= 2'd2), 32'd1);
        if (hold_v) begin
          check_eq("stall_valid", 32'(out_valid), 32'd1);
          check_eq("stall_data", 32'(out_data), 32'(hold_d));
          check_eq("stall_last", 32'(out_last), 32'(hold_l));
        end
        if (!out_valid) begin
          check_eq("last_without_valid", 32'(out_last), 32'd0);
        end
        if (out_valid && out_ready) begin
          check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check_eq("data", 32'(out_data), 32'(exp_q[0]));
            check_eq("last", 32'(out_last), 32'(exp_q.size() == 1));
            void'(exp_q.pop_front());
          end
          hs_cnt++;
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
      end
    end
  end

  // One burst: push expectations, start it, follow it to done and check the aftermath
  task automatic run_burst(input int base, input int len, input bit pulse_start);
    int cyc;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model[(base + i) % N]);
    end
    hs_cnt    = 0;
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      check_eq("busy_run", 32'(busy), 32'd1);
      if (!rdy_mode) begin
        if (cyc <= len) begin
          check_eq("rdaddress", 32'(rdaddress), 32'((base + cyc - 1) % N));
        end
        check_eq("valid_window", 32'(out_valid), 32'(cyc >= 3 && cyc <= len + 2));
      end
      if (pulse_start && cyc == 3) begin
        start     = 1'b1;
        base_addr = AW'(9);
        length    = (AW + 1)'(3);
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("busy_at_done", 32'(busy), 32'd1);
    check_eq("valid_at_done", 32'(out_valid), 32'd0);
    if (!rdy_mode) begin
      check_eq("done_cycle", 32'(cyc), 32'((len == 0) ? 1 : len + 3));
    end
    tick();
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_fall", 32'(busy), 32'd0);
    check_eq("handshakes", hs_cnt, 32'(len));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    hs_cnt    = 0;
    rdy_mode  = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    wren      = 1'b0;
    wdata     = '0;
    wraddress = '0;

    // Preload the RAM during reset
    for (int i = 0; i < int'(N); i++) begin
      model[i]  = W'(i + 'h10);
      wren      = 1'b1;
      wraddress = AW'(i);
      wdata     = model[i];
      tick();
    end
    wren = 1'b0;
    tick();

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_rdaddress", 32'(rdaddress), 32'd0);
    rst = 1'b0;
    tick();

    // Basic burst, wrap-around, full RAM sweep
    run_burst(3, 5, 1'b0);
    run_burst(14, 4, 1'b0);
    run_burst(0, 16, 1'b0);

    // Zero-length burst
    run_burst(7, 0, 1'b0);

    // Backpressure
    rdy_mode = 1'b1;
    run_burst(6, 8, 1'b0);
    run_burst(12, 8, 1'b0);
    rdy_mode = 1'b0;
    tick();
    tick();

    // Start pulsed mid-burst is ignored
    run_burst(2, 6, 1'b1);

    // Reset mid-burst while a word is in flight
    start     = 1'b1;
    base_addr = AW'(5);
    length    = (AW + 1)'(6);
    tick();
    start = 1'b0;
    tick();
    check_eq("inflight_before_rst", 32'(dut.inflight_q), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    run_burst(1, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
